// File: rtl/hazard_if.sv
// Pipeline-to-hazard-scheduler bundle: D/E/M/W register tags, MD handshake and
// the stall/enable/forwarding controls returned to the pipeline.
interface hazard_if;
    logic [4:0] A1_D;
    logic [4:0] A2_D;
    logic [2:0] Tuse_rs_D;
    logic [2:0] Tuse_rt_D;
    logic [4:0] A1_E;
    logic [4:0] A2_E;
    logic [4:0] A3_E;
    logic [4:0] Tnew_E;
    logic [4:0] A2_M;
    logic [4:0] A3_M;
    logic [4:0] Tnew_M;
    logic [4:0] A3_W;
    logic       md_use_D;
    logic       md_start_E;
    logic       md_div_E;
    logic       freeze;

    logic       stall;
    logic       en_PC;
    logic       en_FD;
    logic       clr_DE;
    logic       en_DE;
    logic       en_EM;
    logic       en_MW;
    logic [1:0] fwd_D_rs;
    logic [1:0] fwd_D_rt;
    logic [1:0] fwd_E_rs;
    logic [1:0] fwd_E_rt;
    logic [1:0] fwd_M_rt;
    logic       md_busy;

    // Pipeline side
    modport master (
        output A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, A1_E, A2_E, A3_E, Tnew_E,
               A2_M, A3_M, Tnew_M, A3_W, md_use_D, md_start_E, md_div_E, freeze,
        input  stall, en_PC, en_FD, clr_DE, en_DE, en_EM, en_MW,
               fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy
    );

    // Scheduler side
    modport slave (
        input  A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, A1_E, A2_E, A3_E, Tnew_E,
               A2_M, A3_M, Tnew_M, A3_W, md_use_D, md_start_E, md_div_E, freeze,
        output stall, en_PC, en_FD, clr_DE, en_DE, en_EM, en_MW,
               fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline with mult/div busy tracking.
// Optional stall_cnt output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_scheduler #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hif
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [2:0] TUSE_NONE = 3'd7;

    // Register 0 is never a real dependency
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // Nearest-stage-first select for a D source; a not-ready nearer match blocks farther ones
    function automatic logic [1:0] fwd_sel_d(input logic [4:0] src,
                                             input logic [4:0] dst_e, input logic rdy_e,
                                             input logic [4:0] dst_m, input logic rdy_m,
                                             input logic [4:0] dst_w);
        if (reg_match(src, dst_e))      return rdy_e ? 2'd1 : 2'd0;
        else if (reg_match(src, dst_m)) return rdy_m ? 2'd2 : 2'd0;
        else if (reg_match(src, dst_w)) return 2'd3;
        else                            return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_sel_e(input logic [4:0] src,
                                             input logic [4:0] dst_m, input logic rdy_m,
                                             input logic [4:0] dst_w);
        if (reg_match(src, dst_m))      return rdy_m ? 2'd2 : 2'd0;
        else if (reg_match(src, dst_w)) return 2'd3;
        else                            return 2'd0;
    endfunction

    // Stall when the producer's result arrives later than the consumer needs it
    function automatic logic src_stall(input logic [4:0] src, input logic [2:0] tuse,
                                       input logic [4:0] dst_e, input logic [4:0] tnew_e,
                                       input logic [4:0] dst_m, input logic [4:0] tnew_m);
        if (tuse == TUSE_NONE)          return 1'b0;
        else if (reg_match(src, dst_e)) return tnew_e > {2'b00, tuse};
        else if (reg_match(src, dst_m)) return tnew_m > {2'b00, tuse};
        else                            return 1'b0;
    endfunction

    logic [CNT_W-1:0] md_cnt;
    logic             rdy_e;
    logic             rdy_m;
    logic             data_stall;
    logic             md_stall;
    logic             stall_c;

    // MD busy counter: newest start reloads, freeze holds
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (!hif.freeze) begin
            if (hif.md_start_E)
                md_cnt <= hif.md_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign hif.md_busy = (md_cnt != '0) | hif.md_start_E;

    always_comb begin
        rdy_e      = (hif.Tnew_E == 5'd0);
        rdy_m      = (hif.Tnew_M == 5'd0);
        data_stall = src_stall(hif.A1_D, hif.Tuse_rs_D, hif.A3_E, hif.Tnew_E, hif.A3_M, hif.Tnew_M)
                   | src_stall(hif.A2_D, hif.Tuse_rt_D, hif.A3_E, hif.Tnew_E, hif.A3_M, hif.Tnew_M);
        md_stall   = hif.md_use_D & hif.md_busy;
        stall_c    = data_stall | md_stall;
    end

    // Enables: freeze holds everything and overrides the stall bubble
    always_comb begin
        hif.stall  = stall_c;
        hif.en_PC  = 1'b1;
        hif.en_FD  = 1'b1;
        hif.clr_DE = 1'b0;
        hif.en_DE  = 1'b1;
        hif.en_EM  = 1'b1;
        hif.en_MW  = 1'b1;
        if (hif.freeze) begin
            hif.en_PC = 1'b0;
            hif.en_FD = 1'b0;
            hif.en_DE = 1'b0;
            hif.en_EM = 1'b0;
            hif.en_MW = 1'b0;
        end else if (stall_c) begin
            hif.en_PC  = 1'b0;
            hif.en_FD  = 1'b0;
            hif.clr_DE = 1'b1;
        end
    end

    always_comb begin
        hif.fwd_D_rs = fwd_sel_d(hif.A1_D, hif.A3_E, rdy_e, hif.A3_M, rdy_m, hif.A3_W);
        hif.fwd_D_rt = fwd_sel_d(hif.A2_D, hif.A3_E, rdy_e, hif.A3_M, rdy_m, hif.A3_W);
        hif.fwd_E_rs = fwd_sel_e(hif.A1_E, hif.A3_M, rdy_m, hif.A3_W);
        hif.fwd_E_rt = fwd_sel_e(hif.A2_E, hif.A3_M, rdy_m, hif.A3_W);
        hif.fwd_M_rt = reg_match(hif.A2_M, hif.A3_W) ? 2'd3 : 2'd0;
    end

`ifdef HAZARD_STALL_CNT_EN
    // Counts cycles the pipe actually lost to a hazard bubble
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_c && !hif.freeze)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler: stalls, forwarding priority,
// freeze override and the mult/div busy sequencer.
module tb_hazard_scheduler;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    hazard_if hif ();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_scheduler #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.A1_D = '0; hif.A2_D = '0;
        hif.Tuse_rs_D = 3'd7; hif.Tuse_rt_D = 3'd7;
        hif.A1_E = '0; hif.A2_E = '0; hif.A3_E = '0; hif.Tnew_E = '0;
        hif.A2_M = '0; hif.A3_M = '0; hif.Tnew_M = '0; hif.A3_W = '0;
        hif.md_use_D = 1'b0; hif.md_start_E = 1'b0; hif.md_div_E = 1'b0;
        hif.freeze = 1'b0;
    endtask

    // Advance to the next negedge with inputs cleared, then let comb logic settle
    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic check_enables(input string tag, input logic [6:0] exp);
        check_eq({tag, "_en"}, {25'd0, hif.stall, hif.en_PC, hif.en_FD, hif.clr_DE,
                                hif.en_DE, hif.en_EM, hif.en_MW}, {25'd0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        // {stall,en_PC,en_FD,clr_DE,en_DE,en_EM,en_MW}
        check_enables("reset", 7'b0110111);
        check_eq("reset_busy", 32'(hif.md_busy), 32'd0);
        check_eq("reset_fwd", {22'd0, hif.fwd_D_rs, hif.fwd_D_rt, hif.fwd_E_rs,
                               hif.fwd_E_rt, hif.fwd_M_rt}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check_eq("reset_stall_cnt", stall_cnt, 32'd0);
`endif

        // Load-use
        next_cycle();
        hif.A1_D = 5'd1; hif.Tuse_rs_D = 3'd1; hif.A3_E = 5'd1; hif.Tnew_E = 5'd2;
        #1 check_enables("loaduse", 7'b1001111);
        next_cycle();
        hif.A1_D = 5'd1; hif.Tuse_rs_D = 3'd1; hif.A3_M = 5'd1; hif.Tnew_M = 5'd1;
        #1 check_eq("loaduse2_stall", 32'(hif.stall), 32'd0);
        check_eq("loaduse2_fwd", 32'(hif.fwd_D_rs), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check_eq("stall_cnt_one", stall_cnt, 32'd1);
`endif

        // Branch vs ALU
        next_cycle();
        hif.A2_D = 5'd3; hif.Tuse_rt_D = 3'd0; hif.A3_E = 5'd3; hif.Tnew_E = 5'd1;
        #1 check_eq("branch_stall", 32'(hif.stall), 32'd1);
        next_cycle();
        hif.A2_D = 5'd3; hif.Tuse_rt_D = 3'd0; hif.A3_E = 5'd3; hif.Tnew_E = 5'd0;
        #1 check_eq("branch_nostall", 32'(hif.stall), 32'd0);
        check_eq("branch_fwd", 32'(hif.fwd_D_rt), 32'd1);

        // $zero never matches
        next_cycle();
        hif.A1_D = 5'd0; hif.Tuse_rs_D = 3'd0; hif.A3_E = 5'd0; hif.Tnew_E = 5'd2;
        #1 check_eq("zero_stall", 32'(hif.stall), 32'd0);
        check_eq("zero_fwd", 32'(hif.fwd_D_rs), 32'd0);

        // E-stage priority M over W
        next_cycle();
        hif.A1_E = 5'd5; hif.A3_M = 5'd5; hif.Tnew_M = 5'd0; hif.A3_W = 5'd5;
        hif.A2_M = 5'd7;
        #1 check_eq("prio_m", 32'(hif.fwd_E_rs), 32'd2);
        check_eq("fwd_m_none", 32'(hif.fwd_M_rt), 32'd0);
        hif.A3_M = 5'd6; hif.A3_W = 5'd5;
        #1 check_eq("prio_w", 32'(hif.fwd_E_rs), 32'd3);
        hif.A3_W = 5'd7;
        #1 check_eq("fwd_m_w", 32'(hif.fwd_M_rt), 32'd3);

        // Not-ready E match blocks a ready M match; unused rs never stalls
        next_cycle();
        hif.A1_D = 5'd4; hif.A3_E = 5'd4; hif.Tnew_E = 5'd1; hif.A3_M = 5'd4;
        hif.A2_E = 5'd4;
        #1 check_eq("block_fwd", 32'(hif.fwd_D_rs), 32'd0);
        check_eq("block_stall", 32'(hif.stall), 32'd0);
        check_eq("fwd_e_rt_m", 32'(hif.fwd_E_rt), 32'd2);
        hif.A3_E = 5'd0;
        #1 check_eq("unblock_fwd", 32'(hif.fwd_D_rs), 32'd2);

        // Freeze overrides a stall
        next_cycle();
        hif.A1_D = 5'd1; hif.Tuse_rs_D = 3'd1; hif.A3_E = 5'd1; hif.Tnew_E = 5'd2;
        hif.freeze = 1'b1;
        #1 check_enables("freeze", 7'b1000000);

        // Mult: busy for issue + 5 cycles
        next_cycle();
        hif.md_start_E = 1'b1; hif.md_use_D = 1'b1;
        #1 check_eq("mult_busy_0", 32'(hif.md_busy), 32'd1);
        check_eq("mult_stall_0", 32'(hif.stall), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            next_cycle();
            hif.md_use_D = 1'b1;
            #1 check_eq($sformatf("mult_busy_%0d", i), 32'(hif.md_busy), (i < 6) ? 32'd1 : 32'd0);
            check_eq($sformatf("mult_stall_%0d", i), 32'(hif.stall), (i < 6) ? 32'd1 : 32'd0);
        end

        // Mult with 2 freeze cycles: busy for 8 cycles
        next_cycle();
        hif.md_start_E = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            hif.freeze = (i == 1 || i == 2);
            #1 check_eq($sformatf("mfrz_busy_%0d", i), 32'(hif.md_busy), (i < 8) ? 32'd1 : 32'd0);
        end

        // Div, then reset mid-operation
        next_cycle();
        hif.md_start_E = 1'b1; hif.md_div_E = 1'b1;
        #1 check_eq("div_busy_0", 32'(hif.md_busy), 32'd1);
        next_cycle();
        #1 check_eq("div_busy_1", 32'(hif.md_busy), 32'd1);
        next_cycle();
        #1 check_eq("div_busy_2", 32'(hif.md_busy), 32'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1 check_eq("div_reset_busy", 32'(hif.md_busy), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check_eq("div_reset_stall_cnt", stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Central stall, flush and forwarding controller for the 5-stage MIPS pipeline.
- Compares D/E/M source registers against E/M/W destinations using the Tuse/Tnew scheme carried by the pipeline registers.
- Drives enables and bubble-insert for PC, F/D, D/E and E/M; selects forwarding sources.
- Owns a mult/div busy sequencer that stalls HI/LO consumers until the operation completes.

Parameters:
- MULT_LAT, 5, cycles mult occupies the MD unit after issue from E.
- DIV_LAT, 10, cycles div occupies the MD unit after issue from E.
- CNT_W, 4, width of the MD busy counter; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- A1_D  in  5  D-stage rs.
- A2_D  in  5  D-stage rt.
- Tuse_rs_D  in  3  cycles until rs needed; 7 = rs unused.
- Tuse_rt_D  in  3  same for rt.
- A1_E  in  5  E-stage rs.
- A2_E  in  5  E-stage rt.
- A3_E  in  5  E-stage write reg (0 = no write).
- Tnew_E  in  5  cycles until E result ready.
- A2_M  in  5  M-stage rt (store data).
- A3_M  in  5  M-stage write reg.
- Tnew_M  in  5  M Tnew (E value minus 1, saturating at 0).
- A3_W  in  5  W-stage write reg.
- md_use_D  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_E  in  1  E instr starts mult/div this cycle.
- md_div_E  in  1  1 = div, 0 = mult (valid with md_start_E).
- freeze  in  1  external memory wait; holds whole pipe.
- stall  out  1  D-stage hazard stall.
- en_PC  out  1  PC write enable.
- en_FD  out  1  F/D register enable.
- clr_DE  out  1  load bubble into D/E.
- en_DE  out  1  D/E register enable.
- en_EM  out  1  E/M register enable.
- en_MW  out  1  M/W register enable.
- fwd_D_rs  out  2  source select for rs; same encoding applies to every fwd_* output: 0 regfile/none, 1 E, 2 M, 3 W.
- fwd_D_rt  out  2  source select for rt.
- fwd_E_rs  out  2  source select for E rs.
- fwd_E_rt  out  2  source select for E rt.
- fwd_M_rt  out  2  source select for M rt.
- md_busy  out  1  MD unit occupied.

Behaviour:
- Register match: stage register equals source, source != 0, dest != 0. Register 0 never matches.
- Data stall, per D source with Tuse != 7:
  - If it matches A3_E, stall when Tnew_E > Tuse.
  - Otherwise, if it matches A3_M, stall when Tnew_M > Tuse.
  - W match never stalls.
- MD stall: md_use_D && md_busy.
- stall = OR of the data stalls and the MD stall.
- Stall response (combinational, same cycle): en_PC=0, en_FD=0, clr_DE=1. en_DE, en_EM and en_MW stay 1.
- Freeze: en_PC, en_FD, en_DE, en_EM and en_MW all 0; clr_DE=0; MD counter holds. Freeze overrides stall.
- Forwarding priority is nearest stage first. A stage is eligible only if it matches and its Tnew==0 (W is always ready).
  - fwd_D_*: E, then M, then W.
  - fwd_E_*: M, then W.
  - fwd_M_rt: W.
  - No eligible match gives 0.
  - A nearer match with Tnew>0 blocks farther stages and gives 0, since the stall logic covers that case.
- MD counter (CNT_W bits):
  - Reset: 0.
  - md_start_E && !freeze: load MULT_LAT or DIV_LAT.
  - Else if count!=0 && !freeze: decrement.
  - md_busy = (count!=0) | md_start_E.
  - A start while busy reloads the counter; this is legal, newest op wins.
- Reset values: count=0, md_busy=0. With all inputs 0, outputs are stall=0, all en=1, clr_DE=0, all fwd=0.
- Reset mid MD op clears count; md_busy=0 the cycle after reset.
- All outputs other than md_busy and the optional counter are combinational from inputs.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits).
  - Increments on every cycle with stall=1 && !freeze.
  - Reset value 0; wraps at 2^32-1 to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Load-use stall. A1_D=1, Tuse_rs_D=1, A3_E=1, Tnew_E=2 -> stall=1, en_PC=0, en_FD=0, clr_DE=1. Next cycle A3_M=1, Tnew_M=1, A3_E=0 -> stall=0, fwd_D_rs=0.
- Branch vs ALU. A2_D=3, Tuse_rt_D=0, A3_E=3, Tnew_E=1 -> stall=1. Then Tnew_E=0 -> stall=0, fwd_D_rt=1.
- $zero. A1_D=0, Tuse_rs_D=0, A3_E=0, Tnew_E=2 -> stall=0, fwd_D_rs=0.
- Priority. A1_E=5, A3_M=5, Tnew_M=0, A3_W=5 -> fwd_E_rs=2. Then A3_M=6 -> fwd_E_rs=3.
- Mult sequencing. MULT_LAT=5, pulse md_start_E=1 with md_div_E=0 -> md_busy=1 for 6 consecutive cycles (issue + 5). md_use_D=1 gives stall=1 throughout, 0 on the 7th cycle. Freeze for 2 cycles extends busy by 2.
- Div plus reset. md_start_E=1, md_div_E=1, reset asserted 3 cycles later -> md_busy=0 next cycle. With the macro defined, stall_cnt=0.
